// File: rtl/i2c_codec_reg_slave_pkg.sv
// Shared constants for the codec-register I2C target: bus address, FSM state codes
// and codec register indices (kept in step with the configuration master's LUT).
package i2c_codec_reg_slave_pkg;

  localparam logic [6:0] SLAVE_ADDR    = 7'h1A;
  localparam int         FILT_LEN      = 3;
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ADDR     = 3'd1;
  localparam state_t ST_ADDR_ACK = 3'd2;
  localparam state_t ST_BYTE1    = 3'd3;
  localparam state_t ST_ACK1     = 3'd4;
  localparam state_t ST_BYTE2    = 3'd5;
  localparam state_t ST_ACK2     = 3'd6;
  localparam state_t ST_IGNORE   = 3'd7;

  localparam logic [6:0] REG_LIN_L     = 7'h00;
  localparam logic [6:0] REG_LIN_R     = 7'h01;
  localparam logic [6:0] REG_HEAD_L    = 7'h02;
  localparam logic [6:0] REG_HEAD_R    = 7'h03;
  localparam logic [6:0] REG_A_PATH    = 7'h04;
  localparam logic [6:0] REG_D_PATH    = 7'h05;
  localparam logic [6:0] REG_POWER     = 7'h06;
  localparam logic [6:0] REG_FORMAT    = 7'h07;
  localparam logic [6:0] REG_SAMPLE    = 7'h08;
  localparam logic [6:0] REG_ACTIVE    = 7'h09;
  localparam logic [6:0] REG_RESET     = 7'h0F;

endpackage

// File: rtl/i2c_codec_reg_slave_if.sv
// Register-write side of the codec I2C target: decoded strobe, address, data and busy.
interface i2c_codec_reg_slave_if;

  logic       oREG_WE;
  logic [6:0] oREG_ADDR;
  logic [8:0] oREG_DATA;
  logic       oBUSY;

  modport slave  (output oREG_WE, output oREG_ADDR, output oREG_DATA, output oBUSY);
  modport master (input  oREG_WE, input  oREG_ADDR, input  oREG_DATA, input  oBUSY);

endinterface

// File: rtl/i2c_codec_reg_slave_line_filter.sv
// Conditions one I2C line: 2-FF synchronizer, FILT_LEN-sample agreement filter and
// single-cycle rise/fall pulses aligned with the filtered level change.
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CNT_W    = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_sync;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;

  // Counter tracks how many consecutive samples disagree with the accepted level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        r_rise  <= r_sync[1];
        r_fall  <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_codec_reg_slave.sv
// Write-only I2C codec-register target: decodes {addr byte, reg/data[8], data[7:0]}
// into a one-cycle register-write strobe, ACKing only its own write address.
module i2c_codec_reg_slave (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  I2C_SCLK,
  inout  wire                   I2C_SDAT,
  i2c_codec_reg_slave_if.slave  regBus
);

  import i2c_codec_reg_slave_pkg::*;

  logic w_sclLevel, w_sclRise, w_sclFall;
  logic w_sdaLevel, w_sdaRise, w_sdaFall;
  logic w_start, w_stop;

  state_t     r_state;
  logic [3:0] r_bitCnt;
  logic [7:0] r_shift;
  logic [7:0] r_byte1;
  logic       r_sdaLow;
  logic       r_we;
  logic [6:0] r_addr;
  logic [8:0] r_data;
  logic       r_busy;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sclFilter (
    .i_clk   (iCLK),
    .i_rst_n (iRST_N),
    .i_line  (I2C_SCLK),
    .o_level (w_sclLevel),
    .o_rise  (w_sclRise),
    .o_fall  (w_sclFall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sdaFilter (
    .i_clk   (iCLK),
    .i_rst_n (iRST_N),
    .i_line  (I2C_SDAT),
    .o_level (w_sdaLevel),
    .o_rise  (w_sdaRise),
    .o_fall  (w_sdaFall)
  );

  assign w_start = w_sdaFall & w_sclLevel;
  assign w_stop  = w_sdaRise & w_sclLevel;

  // STOP outranks START; both abort whatever transfer is in flight and drop the ACK.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_byte1  <= '0;
      r_sdaLow <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sdaLow <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= ST_ADDR;
        r_bitCnt <= '0;
        r_sdaLow <= 1'b0;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          ST_ADDR, ST_BYTE1, ST_BYTE2: begin
            if (w_sclRise && (r_bitCnt < BITS_PER_BYTE)) begin
              r_shift  <= {r_shift[6:0], w_sdaLevel};
              r_bitCnt <= r_bitCnt + 4'd1;
            end else if (w_sclFall && (r_bitCnt == BITS_PER_BYTE)) begin
              case (r_state)
                ST_ADDR: begin
                  if (r_shift == {SLAVE_ADDR, 1'b0}) begin
                    r_state  <= ST_ADDR_ACK;
                    r_sdaLow <= 1'b1;
                  end else begin
                    r_state <= ST_IGNORE;
                  end
                end
                ST_BYTE1: begin
                  r_byte1  <= r_shift;
                  r_state  <= ST_ACK1;
                  r_sdaLow <= 1'b1;
                end
                default: begin
                  r_state  <= ST_ACK2;
                  r_sdaLow <= 1'b1;
                  r_addr   <= r_byte1[7:1];
                  r_data   <= {r_byte1[0], r_shift};
                  r_we     <= 1'b1;
                end
              endcase
            end
          end
          ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
            if (w_sclFall) begin
              r_sdaLow <= 1'b0;
              r_bitCnt <= '0;
              case (r_state)
                ST_ADDR_ACK: r_state <= ST_BYTE1;
                ST_ACK1:     r_state <= ST_BYTE2;
                default:     r_state <= ST_IGNORE;
              endcase
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign I2C_SDAT = r_sdaLow ? 1'b0 : 1'bz;

  assign regBus.oREG_WE   = r_we;
  assign regBus.oREG_ADDR = r_addr;
  assign regBus.oREG_DATA = r_data;
  assign regBus.oBUSY     = r_busy;

endmodule

// File: doc/i2c_codec_reg_slave.md
# i2c_codec_reg_slave

I2C target (responder) that receives the same 24-bit write transactions our I2C configuration master issues: slave address, then two bytes carrying a 7-bit register address and 9-bit data in codec format. It sits on the shared I2C_SCLK/I2C_SDAT pins as a codec-register endpoint. It decodes completed writes into a single-cycle register-write strobe, either for an FPGA-side codec model or for loopback verification of the configuration sequence. The block is write-only; it oversamples the bus with the system clock.

## Interface
- SLAVE_ADDR, 7'h1A: 7-bit target address; the 8-bit write address byte is 8'h34.
- FILT_LEN, 3: number of consecutive identical samples required to accept a new SCL/SDA level (glitch filter).
- iCLK  input  1  system clock, at least 20x the I2C bit rate.
- iRST_N  input  1  reset; synchronous, active-low, sampled on posedge iCLK.
- I2C_SCLK  input  1  I2C clock from the master.
- I2C_SDAT  inout  1  I2C data; the block drives only 1'b0 or 1'bz.
- oREG_WE  output  1  one-cycle pulse when a complete, fully ACKed write has been received.
- oREG_ADDR  output  7  register address; valid while oREG_WE=1 and held afterwards.
- oREG_DATA  output  9  register data; valid while oREG_WE=1 and held afterwards.
- oBUSY  output  1  high from an accepted START until the next STOP.

## Operation
- Input conditioning:
  - 2-FF synchronizer on SCL and SDA, then a FILT_LEN-sample majority-free filter.
  - The filtered level changes only after FILT_LEN identical consecutive samples.
  - Edge and condition detection uses filtered signals only.
- Bus conditions:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Data bits are sampled on the filtered SCL rising edge, MSB first.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
  - ADDR_ACK.
  - BYTE1: {reg[6:0], data[8]}.
  - ACK1.
  - BYTE2: data[7:0].
  - ACK2.
  - IGNORE.
- ADDR completes 8 bits:
  - If byte[7:1]==SLAVE_ADDR and byte[0]==0, go to ADDR_ACK.
  - Otherwise (address mismatch or read request), go to IGNORE with no ACK.
- ACK states:
  - On the SCL falling edge that ends bit 8, drive SDA low.
  - Release SDA on the next SCL falling edge, then advance: ADDR_ACK→BYTE1, ACK1→BYTE2, ACK2→IGNORE.
- Write strobe:
  - On entry to ACK2, latch oREG_ADDR=byte1[7:1] and oREG_DATA={byte1[0], byte2}.
  - Pulse oREG_WE on that same cycle.
- Extra bytes after ACK2 are not ACKed (IGNORE); the block waits for STOP or a repeated START.
- Priority and boundary rules:
  - STOP in any state: release SDA, go to IDLE, oBUSY=0. A partial transaction produces no strobe.
  - Repeated START in any state: release SDA, go to ADDR, clear the bit counter.
  - START and STOP cannot coincide, because each needs an opposite SDA edge. If filtering merges events, STOP wins.
  - The bit counter is 4 bits and counts 0..8. It is reset on entry to every shift state.
- Reset (iRST_N=0 on a clock edge), including mid-transfer:
  - State IDLE, SDA released (z), oREG_WE=0, oREG_ADDR=0, oREG_DATA=0, oBUSY=0.
  - Filter and synchronizer flops preset to 1 (idle bus).

## Timing
- Input latency: 2 sync cycles + FILT_LEN cycles from a pin change to the detected edge. Default: 5 iCLK.
- ACK drive begins 1 iCLK after the detected SCL falling edge that ends bit 8. This lies well inside SCL low, given ≥20x oversampling.
- oREG_WE asserts 1 iCLK after the detected SCL falling edge ending bit 8 of BYTE2. It is exactly one cycle wide.
- SDA is never driven while filtered SCL=1, except while holding ACK low across the 9th SCL high phase.

## Structure
- Shared package holds:
  - FSM state enum.
  - Codec address constant 7'h1A.
  - Codec register-index constants (0x00–0x09, 0x0F reset), shared with the configuration master's LUT.
- One sub-module: i2c_line_filter (synchronizer + FILT_LEN filter + rise/fall detect), instantiated twice, once for SCL and once for SDA.

## Test plan
- Write 8'h34, 8'h08, 8'hF8 at 20 kHz: three ACKs, and oREG_WE pulses once with ADDR=7'h04, DATA=9'h0F8.
- Address 8'h40: NACK on the 9th clock, SDA never driven, no strobe, oBUSY=1 until STOP.
- Address 8'h35 (read): NACK, no strobe.
- STOP after BYTE1: ACK on the address and BYTE1, no strobe, state IDLE.
- Repeated START mid-BYTE2, then a full write 8'h34, 8'h12, 8'h01: a single strobe with ADDR=7'h09, DATA=9'h001.
- 2-cycle SCL glitch during BYTE1 is ignored, producing the correct data. Reset asserted during ACK1 releases SDA on the next edge and outputs return to 0.
- Run the full configuration master sequence: 10 strobes in order, matching the master's LUT values.
